cache_data_array: RTL
=====================

# cache_data_array

Parametrised set-associative cache storage array: the next generation of the instruction/data cache memory wrapper. It adds internal parallel tag compare, dirty bits, tree pseudo-LRU replacement, byte-enable word writes, and a request/response handshake with one-cycle latency. It also provides a multi-cycle invalidate-all (flush) sequencer. It sits between the cache controller FSM and the `sp_ram_wrap` instances.

## Interface
Parameters:
- `WAY_COUNT`, 2, associativity; power of two, 1..8
- `SET_COUNT`, 64, sets; power of two, ≥2
- `WAY_WORD_COUNT`, 4, 32-bit words per line; power of two, ≥2
- `ADDR_WIDTH`, 32, byte address width; tag width `TW = ADDR_WIDTH-2-log2(WAY_WORD_COUNT)-log2(SET_COUNT)`

Ports:
- `clk` in 1: single clock
- `rstn_i` in 1: synchronous, active-low reset
- `req_valid_i` in 1: request valid
- `req_ready_o` out 1: request accepted when valid&ready
- `req_op_i` in 2: LOOKUP=0, WRITE_WORD=1, FILL=2, INVALIDATE=3
- `req_addr_i` in ADDR_WIDTH: word `[2+:log2 WWC]`, set above, tag above
- `req_wdata_i` in 32, `req_be_i` in 4: WRITE_WORD data / byte enables
- `fill_line_i` in WAY_WORD_COUNT*32: FILL line, word 0 in LSBs
- `flush_i` in 1: start invalidate-all
- `flush_busy_o` out 1: flush in progress
- `rsp_valid_o` out 1: one-cycle response pulse
- `rsp_hit_o` out 1, `rsp_way_o` out log2(WAY_COUNT) (min 1): hit/filled way
- `rsp_rdata_o` out 32: addressed word of hit way
- `rsp_line_o` out WAY_WORD_COUNT*32: line of hit way, or of the victim way on a miss
- `rsp_victim_way_o` out log2(WAY_COUNT), `rsp_victim_tag_o` out TW, `rsp_victim_dirty_o` out 1

## Operation
- Storage: valid, dirty, tag and pLRU bits live in flops, with `WAY_COUNT-1` pLRU bits per set. Data uses `WAY_COUNT*WAY_WORD_COUNT` `sp_ram_wrap` instances, each one word wide and SET_COUNT deep, all read every accepted request.
- Hit on the accept cycle: valid[set][w] and tag match, computed combinationally from the flops.
- Victim: the lowest-index invalid way; otherwise the pLRU tree victim. With `WAY_COUNT=1` the victim is always way 0.
- LOOKUP:
  - Hit: return word and line; update pLRU to make the way MRU.
  - Miss: report victim way, tag, dirty and line; no state change.
- WRITE_WORD:
  - Hit: write the bytes selected by `req_be_i` into the addressed word; set dirty; update pLRU.
  - Miss: no state change; `rsp_hit_o=0`.
- FILL:
  - Write the full line into the victim way; set valid and tag; clear dirty; make the way MRU.
  - `rsp_way_o` = filled way. Victim outputs report the pre-fill way contents, for writeback.
  - If the address already hits, it refills the hit way instead.
- INVALIDATE:
  - Hit: clear valid and dirty; `rsp_victim_dirty_o` and line return the prior contents.
  - Miss: no change.
- FSM states:
  - IDLE: `req_ready_o = !flush_i`.
  - FLUSH: clear valid, dirty and pLRU of one set per cycle, starting from set 0. The transition back to IDLE is taken after set SET_COUNT-1.
- `flush_i` is sampled only in IDLE and has priority over a simultaneous request (that request is not accepted). `flush_i` during FLUSH is ignored.

## Timing
- Request accepted in cycle N → `rsp_valid_o` high in cycle N+1, for exactly one cycle. Other `rsp_*` outputs are meaningful only while `rsp_valid_o` is high.
- Full throughput in IDLE: back-to-back requests to any address. A write in cycle N is visible to a read accepted in cycle N+1.
- Flush occupies exactly SET_COUNT cycles:
  - `flush_busy_o` high from the cycle after `flush_i` is sampled.
  - `req_ready_o` low on the `flush_i` cycle and all FLUSH cycles.
- Reset (`rstn_i=0` at a clock edge):
  - Clears all valid, dirty and pLRU flops; FSM goes to IDLE.
  - Output values after that edge: `rsp_*`=0, `flush_busy_o`=0, `req_ready_o`=1.
  - Reset mid-flush aborts the flush; the array is fully invalid anyway.
  - Data RAM contents are not cleared.

## Structure
- Package `cache_pkg`: `cache_op_e` enum, FSM state enum, and address-field width/offset functions derived from the parameters.
- Sub-module `cache_plru`: combinational tree pLRU for one set (`WAY_COUNT-1` bits). Inputs are the current bits and the accessed way; outputs are the next bits and the victim way.

## Test plan
Defaults; set `0x23` = addresses `0x1230`, `0x1630`, `0x1A30`.
- Reset, then LOOKUP `0x1230` → next cycle `rsp_valid_o=1`, `hit=0`, `victim_way=0`, `victim_dirty=0`.
- FILL `0x1230` with words `0x00000000,0x11111111,0x22222222,0x33333333` (word 0 first), then LOOKUP `0x1238` → `hit=1`, `way=0`, `rdata=0x22222222`.
- FILL `0x1630` → way 1; LOOKUP `0x1230` (hit); FILL `0x1A30` → `victim_way=1`, `victim_tag=0x5`, `way=1`.
- WRITE_WORD `0x1234`, `be=0011`, data `0xAAAABBBB` → a following LOOKUP returns `0x1111BBBB`; a later FILL that evicts that way reports `victim_dirty=1`.
- `flush_i` together with `req_valid_i` → request not accepted; `req_ready_o` low for 65 cycles and `flush_busy_o` high for 64 cycles. LOOKUP `0x1230` afterwards → `hit=0`.
- `rstn_i` low on flush cycle 10 → next cycle `req_ready_o=1`, `flush_busy_o=0`, and LOOKUP misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the cache data array.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: request opcode enum, sequencer state enum, and width/offset
// helpers that derive the word/set/tag split of a byte address from the
// array geometry.
package cache_pkg;

   typedef enum logic [1:0] {
      OP_LOOKUP     = 2'd0,
      OP_WRITE_WORD = 2'd1,
      OP_FILL       = 2'd2,
      OP_INVALIDATE = 2'd3
   } cache_op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } cache_state_e;

   // Byte offset of the word-select field (words are 32 bits).
   localparam int WORD_OFFSET = 2;

   // Way index width; a direct-mapped array still carries a 1-bit way field.
   function automatic int way_bits(input int way_count);
      return (way_count > 1) ? $clog2(way_count) : 1;
   endfunction

   // Tree pLRU bits per set; kept at least 1 so the storage is never zero-width.
   function automatic int plru_width(input int way_count);
      return (way_count > 1) ? way_count - 1 : 1;
   endfunction

   function automatic int set_offset(input int way_word_count);
      return WORD_OFFSET + $clog2(way_word_count);
   endfunction

   function automatic int tag_offset(input int way_word_count, input int set_count);
      return set_offset(way_word_count) + $clog2(set_count);
   endfunction

   function automatic int tag_width(input int addr_width, input int way_word_count,
                                    input int set_count);
      return addr_width - tag_offset(way_word_count, set_count);
   endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set: next-state bits and victim way.
// Latency: purely combinational.
// Backpressure: n/a.
//
// Ports: cur_bits_i current tree bits (heap order, node n has children
// 2n+1 / 2n+2); access_way_i way being touched; next_bits_o bits with that
// way made MRU; victim_way_o way the tree currently points at.
// A node bit of 1 steers the victim walk to the right child.
module cache_plru
   import cache_pkg::*;
#(
   parameter int WAY_COUNT = 2,
   localparam int PW       = plru_width(WAY_COUNT),
   localparam int WB       = way_bits(WAY_COUNT)
) (
   input  logic [PW-1:0] cur_bits_i,
   input  logic [WB-1:0] access_way_i,
   output logic [PW-1:0] next_bits_o,
   output logic [WB-1:0] victim_way_o
);

   if (WAY_COUNT == 1) begin : g_single
      assign next_bits_o  = '0;
      assign victim_way_o = '0;
      logic unused_plru_in;
      assign unused_plru_in = ^{cur_bits_i, access_way_i};
   end else begin : g_tree
      localparam int LV = $clog2(WAY_COUNT);

      // Follow the node bits from the root down to a leaf.
      always_comb begin : victim_walk
         int node;
         node = 0;
         for (int l = 0; l < LV; l++) begin
            node = 2 * node + 1 + (cur_bits_i[node] ? 1 : 0);
         end
         victim_way_o = WB'(node - (WAY_COUNT - 1));
      end

      // Walk the accessed way's path, pointing each node away from it.
      always_comb begin : mru_update
         int node;
         next_bits_o = cur_bits_i;
         node        = 0;
         for (int l = 0; l < LV; l++) begin
            if (access_way_i[LV-1-l]) begin
               next_bits_o[node] = 1'b0;
               node              = 2 * node + 2;
            end else begin
               next_bits_o[node] = 1'b1;
               node              = 2 * node + 1;
            end
         end
      end
   end

endmodule

// File: rtl/sp_ram_wrap.sv
// Single-port RAM wrapper: one word wide, byte-writable, read-before-write.
// Latency: read data appears the cycle after an enabled access.
// Backpressure: none; an access is taken every cycle en_i is high.
//
// Ports: clk; en_i access enable; addr_i word address; we_i/be_i write
// enable and byte enables; wdata_i write data; rdata_o registered read data
// (old contents when the same address is written in the same cycle).
module sp_ram_wrap #(
   parameter int RAM_SIZE   = 64,
   parameter int DATA_WIDTH = 32,
   localparam int AW        = $clog2(RAM_SIZE),
   localparam int BW        = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [AW-1:0]         addr_i,
   input  logic                  we_i,
   input  logic [BW-1:0]         be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

   always_ff @(posedge clk) begin
      if (en_i) begin
         rdata_o <= mem[addr_i];
         if (we_i) begin
            for (int b = 0; b < BW; b++) begin
               if (be_i[b]) begin
                  mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
               end
            end
         end
      end
   end

endmodule

// File: rtl/cache_data_array.sv
// Set-associative cache storage: tag compare, dirty, pLRU, fill/write/invalidate, flush.
// Latency: response pulse one cycle after acceptance; flush takes SET_COUNT cycles.
// Backpressure: req_ready_o low while a flush is requested or running, else always ready.
//
// Ports: clk, rstn_i (sync, active low); req_valid_i/req_ready_o handshake
// with req_op_i, req_addr_i, req_wdata_i, req_be_i, fill_line_i; flush_i and
// flush_busy_o for invalidate-all; rsp_valid_o pulse with rsp_hit_o,
// rsp_way_o, rsp_rdata_o, rsp_line_o and the victim way/tag/dirty report.
module cache_data_array
   import cache_pkg::*;
#(
   parameter int WAY_COUNT      = 2,
   parameter int SET_COUNT      = 64,
   parameter int WAY_WORD_COUNT = 4,
   parameter int ADDR_WIDTH     = 32,
   localparam int WB            = way_bits(WAY_COUNT),
   localparam int TW            = tag_width(ADDR_WIDTH, WAY_WORD_COUNT, SET_COUNT),
   localparam int LW            = WAY_WORD_COUNT * 32
) (
   input  logic                  clk,
   input  logic                  rstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   input  logic [3:0]            req_be_i,
   input  logic [LW-1:0]         fill_line_i,
   input  logic                  flush_i,
   output logic                  flush_busy_o,
   output logic                  rsp_valid_o,
   output logic                  rsp_hit_o,
   output logic [WB-1:0]         rsp_way_o,
   output logic [31:0]           rsp_rdata_o,
   output logic [LW-1:0]         rsp_line_o,
   output logic [WB-1:0]         rsp_victim_way_o,
   output logic [TW-1:0]         rsp_victim_tag_o,
   output logic                  rsp_victim_dirty_o
);

   localparam int WL      = $clog2(WAY_WORD_COUNT);
   localparam int SL      = $clog2(SET_COUNT);
   localparam int SET_OFF = set_offset(WAY_WORD_COUNT);
   localparam int TAG_OFF = tag_offset(WAY_WORD_COUNT, SET_COUNT);
   localparam int PW      = plru_width(WAY_COUNT);

   // ---------------------------------------------------------------- state
   cache_state_e         state_q, state_d;
   logic [SL-1:0]        flush_cnt_q;
   logic                 flush_clr;

   logic [WAY_COUNT-1:0] valid_q [SET_COUNT];
   logic [WAY_COUNT-1:0] dirty_q [SET_COUNT];
   logic [PW-1:0]        plru_q  [SET_COUNT];
   logic [TW-1:0]        tag_q   [SET_COUNT][WAY_COUNT];

   // ------------------------------------------------------- request decode
   cache_op_e            op;
   logic [SL-1:0]        set_idx;
   logic [WL-1:0]        word_idx;
   logic [TW-1:0]        tag_in;
   logic                 acc;

   logic [WAY_COUNT-1:0] hit_vec, inv_vec;
   logic                 hit, any_inv;
   logic [WB-1:0]        hit_way, inv_way, plru_victim, victim_way, tgt_way;
   logic [PW-1:0]        plru_next;
   logic                 plru_upd;

   logic [31:0]          ram_rdata [WAY_COUNT][WAY_WORD_COUNT];

   // Byte-within-word bits carry no meaning for word-granular storage.
   logic                 unused_addr;
   assign unused_addr = ^req_addr_i[1:0];

   assign op       = cache_op_e'(req_op_i);
   assign set_idx  = req_addr_i[SET_OFF +: SL];
   assign word_idx = req_addr_i[WORD_OFFSET +: WL];
   assign tag_in   = req_addr_i[TAG_OFF +: TW];
   assign acc      = req_valid_i && req_ready_o;

   for (genvar w = 0; w < WAY_COUNT; w++) begin : g_cmp
      assign hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in);
   end
   assign inv_vec = ~valid_q[set_idx];
   assign hit     = |hit_vec;
   assign any_inv = |inv_vec;

   // Lowest-index hit and lowest-index invalid way.
   always_comb begin
      hit_way = '0;
      inv_way = '0;
      for (int w = WAY_COUNT - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WB'(w);
         if (inv_vec[w]) inv_way = WB'(w);
      end
   end

   assign victim_way = any_inv ? inv_way : plru_victim;
   // Way the request acts on: the hit way, else the replacement candidate.
   // A FILL that already hits therefore refills in place.
   assign tgt_way    = hit ? hit_way : victim_way;

   cache_plru #(.WAY_COUNT(WAY_COUNT)) u_plru (
      .cur_bits_i   (plru_q[set_idx]),
      .access_way_i (tgt_way),
      .next_bits_o  (plru_next),
      .victim_way_o (plru_victim)
   );

   assign plru_upd = acc && ((op == OP_FILL) ||
                             (hit && ((op == OP_LOOKUP) || (op == OP_WRITE_WORD))));

   // ------------------------------------------------------ flush sequencer
   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + SL'(1) : '0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (flush_i) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_cnt_q == SL'(SET_COUNT - 1)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready_o  = 1'b0;
      flush_busy_o = 1'b0;
      flush_clr    = 1'b0;
      case (state_q)
         ST_IDLE:  req_ready_o = !flush_i;
         ST_FLUSH: begin
            flush_busy_o = 1'b1;
            flush_clr    = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------ valid / dirty / pLRU
   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         for (int s = 0; s < SET_COUNT; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else if (flush_clr) begin
         valid_q[flush_cnt_q] <= '0;
         dirty_q[flush_cnt_q] <= '0;
         plru_q[flush_cnt_q]  <= '0;
      end else if (acc) begin
         if (plru_upd) plru_q[set_idx] <= plru_next;
         case (op)
            OP_WRITE_WORD: if (hit) dirty_q[set_idx][hit_way] <= 1'b1;
            OP_FILL: begin
               valid_q[set_idx][tgt_way] <= 1'b1;
               dirty_q[set_idx][tgt_way] <= 1'b0;
            end
            OP_INVALIDATE: if (hit) begin
               valid_q[set_idx][hit_way] <= 1'b0;
               dirty_q[set_idx][hit_way] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Tags are qualified by valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (acc && (op == OP_FILL)) begin
         tag_q[set_idx][tgt_way] <= tag_in;
      end
   end

   // ------------------------------------------------------------ data RAMs
   // Every accepted request reads all words of all ways of the set; writes
   // are read-before-write, so a FILL still returns the evicted line.
   for (genvar w = 0; w < WAY_COUNT; w++) begin : g_way
      for (genvar k = 0; k < WAY_WORD_COUNT; k++) begin : g_word
         logic        we;
         logic [31:0] wdata;
         logic [3:0]  be;

         assign we = acc &&
                     (((op == OP_FILL) && (tgt_way == WB'(w))) ||
                      ((op == OP_WRITE_WORD) && hit && (hit_way == WB'(w)) &&
                       (word_idx == WL'(k))));
         assign wdata = (op == OP_FILL) ? fill_line_i[k*32 +: 32] : req_wdata_i;
         assign be    = (op == OP_FILL) ? 4'hF : req_be_i;

         sp_ram_wrap #(
            .RAM_SIZE   (SET_COUNT),
            .DATA_WIDTH (32)
         ) u_ram (
            .clk     (clk),
            .en_i    (acc),
            .addr_i  (set_idx),
            .we_i    (we),
            .be_i    (be),
            .wdata_i (wdata),
            .rdata_o (ram_rdata[w][k])
         );
      end
   end

   // ------------------------------------------------------------- response
   logic          rsp_valid_q, rsp_hit_q, rsp_vdirty_q;
   logic [WB-1:0] rsp_way_q, rsp_sel_q;
   logic [WL-1:0] rsp_word_q;
   logic [TW-1:0] rsp_vtag_q;

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         rsp_valid_q  <= 1'b0;
         rsp_hit_q    <= 1'b0;
         rsp_way_q    <= '0;
         rsp_sel_q    <= '0;
         rsp_word_q   <= '0;
         rsp_vtag_q   <= '0;
         rsp_vdirty_q <= 1'b0;
      end else begin
         rsp_valid_q <= acc;
         if (acc) begin
            rsp_hit_q    <= hit;
            rsp_way_q    <= (hit || (op == OP_FILL)) ? tgt_way : '0;
            rsp_sel_q    <= tgt_way;
            rsp_word_q   <= word_idx;
            rsp_vtag_q   <= tag_q[set_idx][tgt_way];
            rsp_vdirty_q <= dirty_q[set_idx][tgt_way];
         end
      end
   end

   // RAM outputs are not reset, so data is forced to zero outside the pulse.
   always_comb begin
      rsp_rdata_o = '0;
      rsp_line_o  = '0;
      if (rsp_valid_q) begin
         rsp_rdata_o = ram_rdata[rsp_sel_q][rsp_word_q];
         for (int k = 0; k < WAY_WORD_COUNT; k++) begin
            rsp_line_o[k*32 +: 32] = ram_rdata[rsp_sel_q][k];
         end
      end
   end

   assign rsp_valid_o        = rsp_valid_q;
   assign rsp_hit_o          = rsp_hit_q;
   assign rsp_way_o          = rsp_way_q;
   assign rsp_victim_way_o   = rsp_sel_q;
   assign rsp_victim_tag_o   = rsp_vtag_q;
   assign rsp_victim_dirty_o = rsp_vdirty_q;

endmodule
